// File: rtl/song_reader_pkg.sv
// song_reader_pkg: shared widths, state encoding and end-of-song marker for the song sequencer
package song_reader_pkg;
  localparam int NOTE_W = 6;
  localparam int DUR_W = 6;
  localparam int IDX_W = 5;
  localparam int DATA_W = NOTE_W + DUR_W;
  localparam logic [DUR_W-1:0] END_MARKER = '0;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DATA  = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_END   = 3'd5
  } state_t;
endpackage

// File: rtl/song_rom.sv
// song_rom: 128x12 registered ROM, address {song_i, idx_i}, data_o = {note, duration} one cycle later
module song_rom
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic [1:0]        song_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] data_o
);
  logic [DATA_W-1:0] data_d;
  // Unlisted entries of songs 0-2 read as all-zero, i.e. the end marker.
  // Song 3 fills all 32 slots so it ends on the last index, not on a marker.
  always_comb begin
    data_d = '0;
    case ({song_i, idx_i})
      {2'd0, 5'd0}: data_d = {6'd1, 6'd4};
      {2'd0, 5'd1}: data_d = {6'd2, 6'd3};
      {2'd1, 5'd0}: data_d = {6'd5, 6'd2};
      {2'd1, 5'd1}: data_d = {6'd0, 6'd3};
      {2'd1, 5'd2}: data_d = {6'd7, 6'd1};
      {2'd2, 5'd0}: data_d = {6'd10, 6'd1};
      {2'd2, 5'd1}: data_d = {6'd11, 6'd2};
      default: data_d = song_i == 2'd3 ? {NOTE_W'(idx_i) + NOTE_W'(1), DUR_W'(idx_i[1:0]) + DUR_W'(1)} : '0;
    endcase
  end
  always_ff @(posedge clk) data_o <= data_d;
endmodule

// File: rtl/song_reader.sv
// song_reader: steps through a song in song_rom and hands {note, duration} to the note player
// Ports: clk; reset/restart sync clears; play gates advancing; song selects ROM bank;
// note_done from player; new_note/song_done 1-cycle pulses; note/duration held outputs.
module song_reader
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              play,
  input  logic [1:0]        song,
  input  logic              note_done,
  output logic              new_note,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic              song_done
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic new_note_q, new_note_d, song_done_q, song_done_d;
  logic [DATA_W-1:0] rom_data;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0] rom_dur;
  logic last;
  // The ROM is addressed every cycle; the value captured at the FETCH->DATA edge is the one used.
  song_rom u_rom (
    .clk    (clk),
    .song_i (song),
    .idx_i  (idx_q),
    .data_o (rom_data)
  );
  assign rom_note = rom_data[DATA_W-1:DUR_W];
  assign rom_dur = rom_data[DUR_W-1:0];
  assign last = idx_q == IDX_MAX;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    note_d = note_q;
    dur_d = dur_q;
    new_note_d = 1'b0;
    song_done_d = 1'b0;
    case (state_q)
      S_IDLE:  state_d = play ? S_FETCH : S_IDLE;
      S_FETCH: state_d = S_DATA;
      S_DATA: begin
        song_done_d = rom_dur == END_MARKER;
        new_note_d = rom_dur != END_MARKER;
        note_d = rom_dur == END_MARKER ? note_q : rom_note;
        dur_d = rom_dur == END_MARKER ? dur_q : rom_dur;
        state_d = rom_dur == END_MARKER ? S_END : S_WAIT;
      end
      S_WAIT: begin
        song_done_d = note_done && last;
        idx_d = note_done && !last ? idx_q + 1'b1 : idx_q;
        state_d = !note_done ? S_WAIT : last ? S_END : S_NEXT;
      end
      S_NEXT:  state_d = play ? S_FETCH : S_NEXT;
      S_END:   state_d = S_END;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      note_q <= '0;
      dur_q <= '0;
      new_note_q <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      note_q <= note_d;
      dur_q <= dur_d;
      new_note_q <= new_note_d;
      song_done_q <= song_done_d;
    end
  end
  assign new_note = new_note_q;
  assign note = note_q;
  assign duration = dur_q;
  assign song_done = song_done_q;
endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: randomized self-checking bench for song_reader against an event-level song model
module tb_song_reader;
  logic clk = 1'b0, reset = 1'b1, restart = 1'b0, play = 1'b0, note_done = 1'b0;
  logic [1:0] song = 2'd0;
  logic new_note, song_done;
  logic [5:0] note, duration;
  logic [5:0] m_note, m_dur;
  int n_tab[4][32];
  int d_tab[4][32];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  song_reader dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .play      (play),
    .song      (song),
    .note_done (note_done),
    .new_note  (new_note),
    .note      (note),
    .duration  (duration),
    .song_done (song_done)
  );

  task automatic do_reset();
    reset = 1'b1;
    restart = 1'b0;
    play = 1'b0;
    note_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_note = '0;
    m_dur = '0;
  endtask

  // A song is a list of entries ending at a zero duration or at entry 31.
  // Each honoured play (IDLE or between notes) yields the next entry two edges later;
  // a note lasts until the player's note_done, sent duration edges after new_note.
  task automatic run_song(input logic [1:0] s, input int pause_pct, input int spur_pct, input int tail);
    int pos = 0, emit_at = -1, nd_at = -1, c = 0, fin_at = -1, notes = 0;
    bit waiting = 1'b1, p;
    logic en, ed;
    song = s;
    while (fin_at < 0 || c < fin_at + tail) begin
      if (c > 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL run_song%0d timeout: song not finished after %0d cycles (notes %0d)", s, c, notes);
        break;
      end
      c++;
      p = $urandom_range(99) >= pause_pct;
      play = p;
      note_done = (c == nd_at) || (nd_at < 0 && $urandom_range(99) < spur_pct);
      @(posedge clk);
      en = 1'b0;
      ed = 1'b0;
      if (waiting && p) begin
        waiting = 1'b0;
        emit_at = c + 2;
      end
      if (c == nd_at) begin
        nd_at = -1;
        if (pos == 31) begin
          ed = 1'b1;
          fin_at = c;
        end else begin
          pos++;
          waiting = 1'b1;
        end
      end
      if (c == emit_at) begin
        emit_at = -1;
        if (d_tab[s][pos] == 0) begin
          ed = 1'b1;
          fin_at = c;
        end else begin
          en = 1'b1;
          notes++;
          m_note = 6'(n_tab[s][pos]);
          m_dur = 6'(d_tab[s][pos]);
          nd_at = c + d_tab[s][pos];
        end
      end
      @(negedge clk);
      n_cmp++;
      if ({new_note, song_done, note, duration} !== {en, ed, m_note, m_dur}) begin
        n_bad++;
        $display("FAIL song%0d cycle%0d: got new_note=%b song_done=%b note=%0d dur=%0d, want %b %b %0d %0d",
                 s, c, new_note, song_done, note, duration, en, ed, m_note, m_dur);
      end
    end
    play = 1'b0;
    note_done = 1'b0;
  endtask

  task automatic wait_first_note(input string tag);
    int k = 0;
    while (new_note !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (new_note !== 1'b1) begin
      n_bad++;
      $display("FAIL %s first_note: new_note=%b after %0d cycles, want 1", tag, new_note, k);
    end
  endtask

  task automatic check_cleared(input string tag);
    n_cmp++;
    if ({new_note, song_done, note, duration} !== 14'd0) begin
      n_bad++;
      $display("FAIL %s cleared: got new_note=%b song_done=%b note=%0d dur=%0d, want all 0",
               tag, new_note, song_done, note, duration);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_cleared("reset");
    note_done = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_cleared("idle_hold");
    end
    note_done = 1'b0;
  endtask

  task automatic test_song0();
    do_reset();
    run_song(2'd0, 0, 0, 6);
  endtask

  task automatic test_pause();
    do_reset();
    run_song(2'd0, 60, 30, 6);
    do_reset();
    run_song(2'd2, 50, 30, 6);
  endtask

  task automatic test_full_song();
    do_reset();
    run_song(2'd3, 0, 0, 8);
    do_reset();
    run_song(2'd3, 30, 20, 10);
  endtask

  task automatic test_restart();
    do_reset();
    song = 2'd0;
    play = 1'b1;
    wait_first_note("restart");
    @(negedge clk);
    restart = 1'b1;
    note_done = 1'b1;
    song = 2'd1;
    @(negedge clk);
    check_cleared("restart");
    restart = 1'b0;
    note_done = 1'b0;
    play = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_cleared("restart_idle");
    end
    m_note = '0;
    m_dur = '0;
    run_song(2'd1, 20, 10, 4);
  endtask

  task automatic test_reset_note_done();
    do_reset();
    song = 2'd0;
    play = 1'b1;
    wait_first_note("rst_nd");
    reset = 1'b1;
    note_done = 1'b1;
    @(negedge clk);
    check_cleared("rst_nd");
    reset = 1'b0;
    note_done = 1'b0;
    play = 1'b0;
    m_note = '0;
    m_dur = '0;
    run_song(2'd0, 0, 0, 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_song(2'($urandom_range(3)), $urandom_range(70), $urandom_range(40), 5);
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 32; i++) begin
        n_tab[s][i] = 0;
        d_tab[s][i] = 0;
      end
    n_tab[0][0] = 1;  d_tab[0][0] = 4;
    n_tab[0][1] = 2;  d_tab[0][1] = 3;
    n_tab[1][0] = 5;  d_tab[1][0] = 2;
    n_tab[1][1] = 0;  d_tab[1][1] = 3;
    n_tab[1][2] = 7;  d_tab[1][2] = 1;
    n_tab[2][0] = 10; d_tab[2][0] = 1;
    n_tab[2][1] = 11; d_tab[2][1] = 2;
    for (int i = 0; i < 32; i++) begin
      n_tab[3][i] = i + 1;
      d_tab[3][i] = (i % 4) + 1;
    end
    test_reset();
    test_song0();
    test_pause();
    test_full_song();
    test_restart();
    test_reset_note_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
